// File: rtl/regfile_pkg.sv
// Shared constants, helpers and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W_DEF = 32;
  localparam int unsigned RF_DEPTH_DEF  = 32;
  localparam int          RF_ZERO_ADDR  = 0;

  typedef logic [RF_DATA_W_DEF-1:0] rf_word_t;

  // A depth of 1 still needs one address bit.
  function automatic int unsigned rf_addr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range/zero-register check, optional write-first bypass
// (REGFILE_MP_BYPASS_EN) and the rdata flop.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W_DEF,
  parameter int unsigned DEPTH    = RF_DEPTH_DEF,
  parameter int unsigned ZERO_REG = 1,
`ifdef REGFILE_MP_BYPASS_EN
  parameter int unsigned NUM_WR   = 1,
`endif
  parameter int unsigned AW       = rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra,
  input  logic [DATA_W-1:0] mem [DEPTH],
`ifdef REGFILE_MP_BYPASS_EN
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Only addresses that match a real, non-hardwired register produce data; anything
  // else (out of range, zero register) stays 0 and is never bypassed.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ra == AW'(i) && !(ZERO_REG != 0 && i == RF_ZERO_ADDR)) begin
        rdata_d = mem[i];
`ifdef REGFILE_MP_BYPASS_EN
        for (int q = 0; q < int'(NUM_WR); q++) begin
          if (we[q] && wa[q*AW +: AW] == ra) begin
            rdata_d = wd[q*DATA_W +: DATA_W];
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads and synchronous clear.
// Define REGFILE_MP_BYPASS_EN for write-first read-during-write; default is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W_DEF,
  parameter int unsigned DEPTH    = RF_DEPTH_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = rf_addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wa,
  input  logic [NUM_WR*DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Ascending port order: the highest-index writer to an address is assigned last and wins.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int q = 0; q < int'(NUM_WR); q++) begin
        if (we[q] && wa[q*AW +: AW] == AW'(i) && !(ZERO_REG != 0 && i == RF_ZERO_ADDR)) begin
          mem_d[i] = wd[q*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
`ifdef REGFILE_MP_BYPASS_EN
      .NUM_WR   (NUM_WR),
`endif
      .AW       (AW)
    ) u_rd (
      .clk   (clk),
      .reset (reset),
      .ra    (ra[p*AW +: AW]),
      .mem   (mem_q),
`ifdef REGFILE_MP_BYPASS_EN
      .we    (we),
      .wa    (wa),
      .wd    (wd),
`endif
      .rdata (rdata[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, randomized traffic against an
// array model, and a ZERO_REG=0 instance.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int DA  = 24;
  localparam int NRA = 3;
  localparam int NWA = 2;
  localparam int AWA = 5;
  localparam int NRB = 2;
  localparam int NWB = 1;
  localparam int AWB = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NRA*AWA-1:0] a_ra;
  logic [NRA*DW-1:0]  a_rdata;
  logic [NWA-1:0]     a_we;
  logic [NWA*AWA-1:0] a_wa;
  logic [NWA*DW-1:0]  a_wd;

  logic [NRB*AWB-1:0] b_ra;
  logic [NRB*DW-1:0]  b_rdata;
  logic [NWB-1:0]     b_we;
  logic [NWB*AWB-1:0] b_wa;
  logic [NWB*DW-1:0]  b_wd;

  regfile_mp #(
    .DATA_W   (DW),
    .DEPTH    (DA),
    .NUM_RD   (NRA),
    .NUM_WR   (NWA),
    .ZERO_REG (1)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .ra    (a_ra),
    .rdata (a_rdata),
    .we    (a_we),
    .wa    (a_wa),
    .wd    (a_wd)
  );

  regfile_mp #(
    .ZERO_REG (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .ra    (b_ra),
    .rdata (b_rdata),
    .we    (b_we),
    .wa    (b_wa),
    .wd    (b_wd)
  );

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [DA];

  typedef struct {
    logic          rst;
    logic [1:0]    we;
    int            wa0;
    logic [DW-1:0] wd0;
    int            wa1;
    logic [DW-1:0] wd1;
    int            ra0;
    int            ra1;
    int            ra2;
    logic [DW-1:0] e0_bp;
    logic [DW-1:0] e0_nb;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a register is a plain array slot; invalid or zero addresses read 0.
  function automatic logic [DW-1:0] a_expect(input int p);
    int addr;
    logic [DW-1:0] r;
    addr = int'(a_ra[p*AWA +: AWA]);
    if (reset || addr >= DA || addr == 0) return '0;
    r = model[addr];
    if (Bypass) begin
      for (int q = 0; q < NWA; q++) begin
        if (a_we[q] && int'(a_wa[q*AWA +: AWA]) == addr) r = a_wd[q*DW +: DW];
      end
    end
    return r;
  endfunction

  task automatic a_cycle(input string tag);
    logic [DW-1:0] e [NRA];
    int addr;
    for (int p = 0; p < NRA; p++) e[p] = a_expect(p);
    if (reset) begin
      for (int i = 0; i < DA; i++) model[i] = '0;
    end else begin
      for (int q = 0; q < NWA; q++) begin
        addr = int'(a_wa[q*AWA +: AWA]);
        if (a_we[q] && addr < DA && addr != 0) model[addr] = a_wd[q*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NRA; p++) begin
      check($sformatf("%s model rdata%0d", tag, p), a_rdata[p*DW +: DW], e[p]);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] we, input int wa0, input logic [DW-1:0] wd0,
                     input int wa1, input logic [DW-1:0] wd1, input int ra0, input int ra1,
                     input int ra2, input logic [DW-1:0] e0_bp, input logic [DW-1:0] e0_nb,
                     input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    vec_t v;
    v = '{rst: rst, we: we, wa0: wa0, wd0: wd0, wa1: wa1, wd1: wd1, ra0: ra0, ra1: ra1, ra2: ra2,
          e0_bp: e0_bp, e0_nb: e0_nb, e1: e1, e2: e2};
    vecs.push_back(v);
  endtask

  task automatic b_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] e0;
    reset = 1'b1;
    a_ra = '0; a_we = '0; a_wa = '0; a_wd = '0;
    b_ra = '0; b_we = '0; b_wa = '0; b_wd = '0;
    for (int i = 0; i < DA; i++) model[i] = '0;

    //  rst we     wa0 wd0           wa1 wd1     ra0 ra1 ra2 e0_bp         e0_nb  e1     e2
    add(1, 2'b00, 0,  32'h0,        0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b01, 5,  32'hDEADBEEF, 0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(1, 2'b00, 0,  32'h0,        0,  32'h0,  5,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  5,  5,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b01, 3,  32'h1234,     0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  3,  0,  3,  32'h1234,     32'h1234, 32'h0, 32'h1234);
    add(0, 2'b01, 0,  32'hFFFFFFFF, 0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b01, 7,  32'hA,        0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b01, 7,  32'hB,        0,  32'h0,  7,  0,  0,  32'hB,        32'hA, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  7,  0,  0,  32'hB,        32'hB, 32'h0, 32'h0);
    add(0, 2'b11, 9,  32'h11,       9,  32'h22, 9,  0,  0,  32'h22,       32'h0, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  9,  9,  9,  32'h22,       32'h22, 32'h22, 32'h22);
    add(0, 2'b01, 23, 32'h77,       0,  32'h0,  0,  0,  0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b01, 30, 32'h55,       0,  32'h0,  30, 23, 23, 32'h0,        32'h0, 32'h77, 32'h77);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  30, 23, 23, 32'h0,        32'h0, 32'h77, 32'h77);
    add(0, 2'b01, 0,  32'h99,       0,  32'h0,  0,  31, 0,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b10, 0,  32'h0,        23, 32'h5A, 23, 0,  0,  32'h5A,       32'h77, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  23, 0,  0,  32'h5A,       32'h5A, 32'h0, 32'h0);
    add(1, 2'b11, 4,  32'h1,        5,  32'h2,  23, 4,  5,  32'h0,        32'h0, 32'h0, 32'h0);
    add(0, 2'b00, 0,  32'h0,        0,  32'h0,  23, 4,  5,  32'h0,        32'h0, 32'h0, 32'h0);

    for (int k = 0; k < vecs.size(); k++) begin
      reset = vecs[k].rst;
      a_we  = vecs[k].we;
      a_wa  = {5'(vecs[k].wa1), 5'(vecs[k].wa0)};
      a_wd  = {vecs[k].wd1, vecs[k].wd0};
      a_ra  = {5'(vecs[k].ra2), 5'(vecs[k].ra1), 5'(vecs[k].ra0)};
      e0    = Bypass ? vecs[k].e0_bp : vecs[k].e0_nb;
      a_cycle($sformatf("vec%0d", k));
      check($sformatf("vec%0d rdata0", k), a_rdata[0 +: DW], e0);
      check($sformatf("vec%0d rdata1", k), a_rdata[DW +: DW], vecs[k].e1);
      check($sformatf("vec%0d rdata2", k), a_rdata[2*DW +: DW], vecs[k].e2);
    end

    // Random traffic; reads often aim at a live write address to hit read-during-write.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      a_we  = 2'($urandom);
      for (int q = 0; q < NWA; q++) begin
        a_wa[q*AWA +: AWA] = 5'($urandom_range(0, 31));
        a_wd[q*DW +: DW]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      for (int p = 0; p < NRA; p++) begin
        if ($urandom_range(0, 1) == 0) a_ra[p*AWA +: AWA] = a_wa[$urandom_range(0, 1)*AWA +: AWA];
        else a_ra[p*AWA +: AWA] = 5'($urandom_range(0, 31));
      end
      a_cycle("rnd");
    end

    // ZERO_REG=0 instance: register 0 is ordinary storage.
    reset = 1'b1;
    a_we  = '0;
    b_we  = '0;
    b_cycle();
    reset = 1'b0;
    b_we = 1'b1; b_wa = 5'd0; b_wd = 32'hFFFFFFFF; b_ra = {5'd0, 5'd0};
    b_cycle();
    check("b reg0 rdw rdata0", b_rdata[0 +: DW], Bypass ? 32'hFFFFFFFF : 32'h0);
    b_we = 1'b1; b_wa = 5'd31; b_wd = 32'h31; b_ra = {5'd0, 5'd0};
    b_cycle();
    check("b reg0 rdata0", b_rdata[0 +: DW], 32'hFFFFFFFF);
    check("b reg0 rdata1", b_rdata[DW +: DW], 32'hFFFFFFFF);
    b_we = 1'b0; b_ra = {5'd0, 5'd31};
    b_cycle();
    check("b reg31 rdata0", b_rdata[0 +: DW], 32'h31);
    check("b reg0 again rdata1", b_rdata[DW +: DW], 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
